// File: rtl/adder_pkg.sv
// Shared definitions for the ripple-carry adder.
// The result type packs {carry, sum} so it can be compared directly against a + b + cin.
package adder_pkg;

  localparam int ADDER_DEFAULT_WIDTH = 4;

  typedef logic [ADDER_DEFAULT_WIDTH:0] adder_result_t;

  function automatic adder_result_t pack_result(input logic cout,
                                                input logic [ADDER_DEFAULT_WIDTH-1:0] sum);
    return {cout, sum};
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell, the leaf of the ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/adder_4bit.sv
// Ripple-carry adder with a combinational result and a one-cycle registered copy.
// Defining ADDER_4BIT_OVF_EN adds the signed-overflow outputs ovf / ovf_q.
module adder_4bit
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             valid_q
`ifdef ADDER_4BIT_OVF_EN
  ,
  output logic             ovf,
  output logic             ovf_q
`endif
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_sum;

  assign w_c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (w_c[i]),
      .sum  (w_sum[i]),
      .cout (w_c[i+1])
    );
  end

  assign sum  = w_sum;
  assign cout = w_c[WIDTH];

  // Stage p0 -> p1: capture on in_valid, hold otherwise; reset clears data too.
  logic [WIDTH-1:0] r_sum_p1;
  logic             r_cout_p1;
  logic             r_vld_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum_p1  <= '0;
      r_cout_p1 <= 1'b0;
      r_vld_p1  <= 1'b0;
    end else begin
      r_vld_p1 <= in_valid;
      if (in_valid) begin
        r_sum_p1  <= w_sum;
        r_cout_p1 <= w_c[WIDTH];
      end
    end
  end

  assign sum_q   = r_sum_p1;
  assign cout_q  = r_cout_p1;
  assign valid_q = r_vld_p1;

`ifdef ADDER_4BIT_OVF_EN
  logic w_ovf;
  logic r_ovf_p1;

  assign w_ovf = w_c[WIDTH] ^ w_c[WIDTH-1];
  assign ovf   = w_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_p1 <= 1'b0;
    end else if (in_valid) begin
      r_ovf_p1 <= w_ovf;
    end
  end

  assign ovf_q = r_ovf_p1;
`endif

endmodule

// File: tb/tb_adder_4bit.sv
// Directed bench for adder_4bit: comb vectors, wrap, registered path, reset, full sweep.
module tb_adder_4bit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a, b;
  logic       cin;
  logic       in_valid;
  logic [3:0] sum, sum_q;
  logic       cout, cout_q, valid_q;
`ifdef ADDER_4BIT_OVF_EN
  logic       ovf, ovf_q;
`endif

  int n_cmp = 0;
  int n_err = 0;

  adder_4bit #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .in_valid (in_valid),
    .sum      (sum),
    .cout     (cout),
    .sum_q    (sum_q),
    .cout_q   (cout_q),
    .valid_q  (valid_q)
`ifdef ADDER_4BIT_OVF_EN
    ,
    .ovf      (ovf),
    .ovf_q    (ovf_q)
`endif
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = 4'd9; b = 4'd3; cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({cout_q, sum_q, valid_q} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_state: got cout_q=%b sum_q=%b valid_q=%b, want all 0", cout_q, sum_q, valid_q);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_comb_vectors();
    // {a, b, cin, exp_cout, exp_sum, exp_ovf}
    logic [14:0] vec [9];
    vec[0] = {4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0};
    vec[1] = {4'b0001, 4'b0001, 1'b0, 1'b0, 4'b0010, 1'b0};
    vec[2] = {4'b0001, 4'b0001, 1'b1, 1'b0, 4'b0011, 1'b0};
    vec[3] = {4'b0111, 4'b0001, 1'b0, 1'b0, 4'b1000, 1'b1};
    vec[4] = {4'b1111, 4'b0001, 1'b0, 1'b1, 4'b0000, 1'b0};
    vec[5] = {4'b1111, 4'b1111, 1'b1, 1'b1, 4'b1111, 1'b0};
    vec[6] = {4'b1100, 4'b0011, 1'b1, 1'b1, 4'b0000, 1'b0};
    vec[7] = {4'b1010, 4'b0101, 1'b0, 1'b0, 4'b1111, 1'b0};
    vec[8] = {4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0};
    for (int i = 0; i < 9; i++) begin
      logic [14:0] v;
      v = vec[i];
      a = v[14:11]; b = v[10:7]; cin = v[6];
      #1;
      n_cmp++;
      if ({cout, sum} !== v[5:1]) begin
        n_err++;
        $display("FAIL comb_vec%0d: got %b, want %b", i, {cout, sum}, v[5:1]);
      end
`ifdef ADDER_4BIT_OVF_EN
      n_cmp++;
      if (ovf !== v[0]) begin
        n_err++;
        $display("FAIL ovf_vec%0d: got %b, want %b", i, ovf, v[0]);
      end
`endif
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    a = 4'b1010; b = 4'b0101; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({valid_q, cout_q, sum_q} !== 6'b1_0_1111) begin
      n_err++;
      $display("FAIL reg_capture: got valid_q=%b cout_q=%b sum_q=%b, want 1 0 1111", valid_q, cout_q, sum_q);
    end
    @(negedge clk);
    a = 4'b0001; b = 4'b0001; in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({valid_q, cout_q, sum_q} !== 6'b0_0_1111) begin
      n_err++;
      $display("FAIL reg_hold: got valid_q=%b cout_q=%b sum_q=%b, want 0 0 1111", valid_q, cout_q, sum_q);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    a = 4'b0011; b = 4'b0100; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({valid_q, cout_q, sum_q} !== 6'b1_0_0111) begin
      n_err++;
      $display("FAIL b2b_first: got valid_q=%b cout_q=%b sum_q=%b, want 1 0 0111", valid_q, cout_q, sum_q);
    end
    a = 4'b1000; b = 4'b1001; cin = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({valid_q, cout_q, sum_q} !== 6'b1_1_0010) begin
      n_err++;
      $display("FAIL b2b_second: got valid_q=%b cout_q=%b sum_q=%b, want 1 1 0010", valid_q, cout_q, sum_q);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    a = 4'b1111; b = 4'b1111; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({valid_q, cout_q, sum_q} !== 6'b1_1_1111) begin
      n_err++;
      $display("FAIL mid_load: got valid_q=%b cout_q=%b sum_q=%b, want 1 1 1111", valid_q, cout_q, sum_q);
    end
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; a = 4'b0110; b = 4'b0010; cin = 1'b1;
    #1;
    n_cmp++;
    if ({cout, sum} !== 5'b0_1001) begin
      n_err++;
      $display("FAIL comb_in_reset: got %b, want 01001", {cout, sum});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({valid_q, cout_q, sum_q} !== 6'b0) begin
      n_err++;
      $display("FAIL mid_reset: got valid_q=%b cout_q=%b sum_q=%b, want 0 0 0000", valid_q, cout_q, sum_q);
    end
`ifdef ADDER_4BIT_OVF_EN
    n_cmp++;
    if (ovf_q !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_ovf: got %b, want 0", ovf_q);
    end
`endif
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({valid_q, cout_q, sum_q} !== 6'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: got valid_q=%b cout_q=%b sum_q=%b, want 0 0 0000", valid_q, cout_q, sum_q);
    end
  endtask

  task automatic test_sweep();
    int bad;
    bad = 0;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          int exp_v;
          logic [4:0] exp5;
          a = ia[3:0]; b = ib[3:0]; cin = ic[0];
          exp_v = ia + ib + ic;
          exp5 = exp_v[4:0];
          #1;
          n_cmp++;
          if ({cout, sum} !== exp5) begin
            n_err++;
            bad++;
            if (bad <= 8)
              $display("FAIL sweep a=%0d b=%0d cin=%0d: got %b, want %b", ia, ib, ic, {cout, sum}, exp5);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    test_reset();
    test_comb_vectors();
    test_registered();
    test_back_to_back();
    test_reset_midstream();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
